mempipe_ctl: RTL and testbench
==============================

Name: mempipe_ctl

Overview:
- Responder end of the mem-pipe request interface driven by loadq, storeq and the fill queue.
- Arbitrates the per-queue mm0 requests and returns a same-cycle grant.
- Carries the granted packet down stages mm1..mm5 and registers the tag-lookup hit at mm3.
- Broadcasts pipe_valid_mm5, pipe_req_pkt_mm5 and pipe_action_mm5 back to all queues, which match on their own ids to complete or re-arbitrate.

Parameters:
- NREQS, 3: number of requesting queues. Index 0 is loadq, 1 is storeq, NREQS-1 is fillq.
- LINE_LSB, 6: lowest address bit of the cache-line index used for conflict compare.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_mm0  in  NREQS  per-queue request valid
- req_pkt_mm0  in  NREQS x $bits(t_mempipe_arb)  per-queue request packet; .addr field used
- gnt_mm0  out  NREQS  one-hot grant, same cycle as req
- block_mm0  in  1  downstream backpressure; no grant while set
- tag_hit_mm3  in  1  lookup hit for the op currently in mm3
- pipe_valid_mm5  out  1  op leaving the pipe
- pipe_req_pkt_mm5  out  $bits(t_mempipe_arb)  packet of the mm5 op
- pipe_action_mm5  out  $bits(t_mempipe_action)  .complete / .recycle for the mm5 op
- fill_req_mm5  out  1  request a line fill for the mm5 miss
- idle  out  1  no valid op in mm1..mm5

Behaviour:
- Reset (synchronous, active-high):
  - All stage valids (mm1..mm5) clear; the round-robin pointer goes to 0.
  - Outputs while reset is held or the pipe is empty: pipe_valid_mm5=0, action=0, fill_req_mm5=0, idle=1.
  - gnt_mm0=0 whenever reset=1.
  - Reset mid-operation discards all in-flight ops with no mm5 report.
- Arbitration (combinational, mm0):
  - Round-robin starting at the pointer, searching upward with wrap.
  - At most one gnt bit is set, and only for a requesting index.
  - gnt_mm0=0 when block_mm0=1 or no request is present.
  - On a grant to index i, the pointer becomes (i+1) mod NREQS at the next edge.
  - The pointer holds when nothing is granted.
  - A requester that is not granted must hold its request; the block keeps no memory of lost requests.
- Pipeline:
  - valid_mm1 <= |gnt_mm0. The mm1 packet is the granted packet.
  - valid and packet shift mm1->mm2->...->mm5 each cycle with no stall.
  - Latency is exactly 5 clocks from a grant edge to pipe_valid_mm5.
  - One op is accepted per cycle; back-to-back grants give back-to-back mm5 outputs.
- Hit tracking:
  - hit_mm4 <= tag_hit_mm3 & valid_mm3; hit_mm5 <= hit_mm4.
  - tag_hit_mm3 is ignored when valid_mm3=0.
- Line conflict:
  - line(x) = addr[MSB:LINE_LSB] of op x.
  - In a cycle where valid_mm5 and ~hit_mm5, every valid op in mm1..mm4 with the same line gets its sticky conflict bit set.
  - The conflict bit travels with the op and clears when the op leaves mm5.
  - An op entering mm1 that cycle does not compare; it is not yet in mm1.
- mm5 action (only when valid_mm5; all zero otherwise):
  - complete = hit_mm5 & ~conflict_mm5.
  - recycle = ~complete.
  - fill_req_mm5 = ~hit_mm5 & ~conflict_mm5. A conflicted miss recycles without a second fill.
  - complete and recycle are mutually exclusive; exactly one is set when valid.
- Simultaneous events:
  - A grant in mm0 and an op leaving mm5 in the same cycle are independent.
  - A conflict set on an op in mm4 is visible at that op's mm5 on the next cycle.
- idle = ~|valid_mm1..mm5. A request in mm0 does not clear idle.

Test Plan:
- Reset held 2 cycles, then all req_mm0=3'b111 for 3 cycles -> gnt sequence 001, 010, 100; pipe_valid_mm5 high on cycles 5, 6, 7 after the first grant; idle=1 before the first grant.
- req_mm0=3'b010 with block_mm0=1 for 4 cycles, then block=0 -> gnt=000 for 4 cycles, then gnt=010; the packet appears at mm5 exactly 5 cycles later.
- Single op addr 0x1000, tag_hit_mm3=1 -> at mm5: complete=1, recycle=0, fill_req_mm5=0.
- Op A addr 0x1000 missing, op B addr 0x1020 hitting, granted the next cycle -> A: recycle=1, fill_req_mm5=1; B: conflict set, recycle=1, fill_req_mm5=0.
- Same as the previous case but B addr 0x1040 (different line) -> B: complete=1.
- Three ops in flight, reset asserted for 1 cycle -> no pipe_valid_mm5 for any of them, idle=1, next grant starts at index 0.

Source files
------------

// File: rtl/mempipe_ctl.sv
// mempipe_ctl: mem-pipe responder; round-robin mm0 arbitration, mm1..mm5 carry, hit and line-conflict tracking
package mempipe_pkg;
  localparam int MEMPIPE_AW = 32;
  typedef struct packed {
    logic [3:0]            id;
    logic [MEMPIPE_AW-1:0] addr;
  } t_mempipe_arb;
  typedef struct packed {
    logic complete;
    logic recycle;
  } t_mempipe_action;
endpackage

module mempipe_ctl
  import mempipe_pkg::*;
#(
  parameter int NREQS    = 3,
  parameter int LINE_LSB = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic         [NREQS-1:0]    req_mm0,
  input  t_mempipe_arb [NREQS-1:0]    req_pkt_mm0,
  output logic         [NREQS-1:0]    gnt_mm0,
  input  logic                        block_mm0,
  input  logic                        tag_hit_mm3,
  output logic                        pipe_valid_mm5,
  output t_mempipe_arb                pipe_req_pkt_mm5,
  output t_mempipe_action             pipe_action_mm5,
  output logic                        fill_req_mm5,
  output logic                        idle
);
  localparam int PW = NREQS > 1 ? $clog2(NREQS) : 1;
  logic [PW-1:0] ptr, gnt_idx;
  logic          any_gnt, miss_mm5, complete;
  logic [5:1]    valid, conflict;
  logic [4:1]    set_conf;
  logic          hit_mm4, hit_mm5;
  t_mempipe_arb  pkt [1:5];
  // Round-robin search from ptr upward with wrap; descending loop lets the nearest requester win
  always_comb begin
    gnt_idx = ptr;
    for (int k = NREQS - 1; k >= 0; k--)
      if (req_mm0[(int'(ptr) + k) % NREQS]) gnt_idx = PW'((int'(ptr) + k) % NREQS);
    any_gnt = |req_mm0 & ~block_mm0 & ~reset;
    gnt_mm0 = any_gnt ? NREQS'(1) << gnt_idx : '0;
  end
  // A missing op in mm5 marks every younger valid op on the same line as conflicted
  always_comb begin
    miss_mm5 = valid[5] & ~hit_mm5;
    for (int k = 1; k <= 4; k++)
      set_conf[k] = miss_mm5 & valid[k] &
                    (pkt[k].addr[MEMPIPE_AW-1:LINE_LSB] == pkt[5].addr[MEMPIPE_AW-1:LINE_LSB]);
  end
  // Control state: arbitration pointer, stage valids, hit and sticky conflict bits
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      valid    <= '0;
      conflict <= '0;
      hit_mm4  <= 1'b0;
      hit_mm5  <= 1'b0;
    end else begin
      if (any_gnt) ptr <= (gnt_idx == PW'(NREQS - 1)) ? '0 : gnt_idx + 1'b1;
      valid    <= {valid[4:1], any_gnt};
      conflict <= {conflict[4:1] | set_conf, 1'b0};
      hit_mm4  <= tag_hit_mm3 & valid[3];
      hit_mm5  <= hit_mm4;
    end
  end
  // Packet payload shifts unconditionally; stage valids qualify it
  always_ff @(posedge clk) begin
    pkt[1] <= req_pkt_mm0[gnt_idx];
    for (int k = 2; k <= 5; k++) pkt[k] <= pkt[k-1];
  end
  // mm5 report, forced quiet while reset is held
  always_comb begin
    pipe_valid_mm5           = valid[5] & ~reset;
    pipe_req_pkt_mm5         = pkt[5];
    complete                 = hit_mm5 & ~conflict[5];
    pipe_action_mm5.complete = pipe_valid_mm5 & complete;
    pipe_action_mm5.recycle  = pipe_valid_mm5 & ~complete;
    fill_req_mm5             = pipe_valid_mm5 & ~hit_mm5 & ~conflict[5];
    idle                     = reset | ~|valid;
  end
endmodule

// File: tb/tb_mempipe_ctl.sv
// tb_mempipe_ctl: table-driven per-cycle vectors plus a mid-flight reset sequence
module tb_mempipe_ctl;
  import mempipe_pkg::*;
  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        blk;
    logic        hit;
    logic [31:0] addr;
    logic [2:0]  gnt;
    logic        v5;
    logic        cmp;
    logic        rcy;
    logic        fill;
    logic        idl;
    logic [31:0] a5;
    logic [3:0]  id5;
  } vec_t;
  logic clk = 0, reset = 1, block_mm0 = 0, tag_hit_mm3 = 0;
  logic [2:0] req_mm0 = '0, gnt_mm0;
  t_mempipe_arb [2:0] req_pkt_mm0;
  logic pipe_valid_mm5, fill_req_mm5, idle;
  t_mempipe_arb pipe_req_pkt_mm5;
  t_mempipe_action pipe_action_mm5;
  int pass = 0, total = 0;
  vec_t tbl[$];
  logic [2:0] eg [3];
  mempipe_ctl #(.NREQS(3), .LINE_LSB(6)) dut (
    .clk(clk), .reset(reset), .req_mm0(req_mm0), .req_pkt_mm0(req_pkt_mm0),
    .gnt_mm0(gnt_mm0), .block_mm0(block_mm0), .tag_hit_mm3(tag_hit_mm3),
    .pipe_valid_mm5(pipe_valid_mm5), .pipe_req_pkt_mm5(pipe_req_pkt_mm5),
    .pipe_action_mm5(pipe_action_mm5), .fill_req_mm5(fill_req_mm5), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else pass++;
  endtask
  function automatic vec_t mk(logic rst, logic [2:0] req, logic blk, logic hit, logic [31:0] addr,
                              logic [2:0] gnt, logic v5, logic cmp, logic rcy, logic fill,
                              logic idl, logic [31:0] a5, logic [3:0] id5);
    vec_t v;
    v = '{rst, req, blk, hit, addr, gnt, v5, cmp, rcy, fill, idl, a5, id5};
    return v;
  endfunction
  task automatic drive(input logic rst, input logic [2:0] req, input logic blk, input logic hit, input logic [31:0] addr);
    reset = rst; req_mm0 = req; block_mm0 = blk; tag_hit_mm3 = hit;
    for (int i = 0; i < 3; i++) req_pkt_mm0[i] = '{id: 4'(i), addr: addr};
  endtask
  initial begin
    tbl.push_back(mk(1, 3'b111, 0, 1, 32'h1000, 3'b000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3'b111, 0, 1, 32'h1000, 3'b000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b111, 0, 1, 32'h1000, 3'b001, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b111, 0, 1, 32'h1000, 3'b010, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 0, 1, 32'h1000, 3'b100, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h1000, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h1000, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h1000, 3'b000, 1, 1, 0, 0, 0, 32'h1000, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h1000, 3'b000, 1, 1, 0, 0, 0, 32'h1000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h1000, 3'b000, 1, 1, 0, 0, 0, 32'h1000, 2));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 3'b010, 1, 1, 32'h2000, 3'b000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0, 1, 32'h2000, 3'b010, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 3'b000, 0, 1, 32'h2000, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h2000, 3'b000, 1, 1, 0, 0, 0, 32'h2000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h2000, 3'b000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 0, 1, 32'h1000, 3'b001, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 0, 1, 32'h1020, 3'b001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 32'h0,    3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 1, 0, 1, 1, 0, 32'h1000, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 1, 0, 1, 0, 0, 32'h1020, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 0, 1, 32'h1000, 3'b001, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 0, 1, 32'h1040, 3'b001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 32'h0,    3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 1, 0, 1, 1, 0, 32'h1000, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 1, 1, 0, 0, 0, 32'h1040, 0));
    tbl.push_back(mk(0, 3'b000, 0, 1, 32'h0,    3'b000, 0, 0, 0, 0, 1, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].blk, tbl[i].hit, tbl[i].addr);
      #1;
      chk($sformatf("row%0d gnt", i), 64'(gnt_mm0), 64'(tbl[i].gnt));
      chk($sformatf("row%0d valid5", i), 64'(pipe_valid_mm5), 64'(tbl[i].v5));
      chk($sformatf("row%0d complete", i), 64'(pipe_action_mm5.complete), 64'(tbl[i].cmp));
      chk($sformatf("row%0d recycle", i), 64'(pipe_action_mm5.recycle), 64'(tbl[i].rcy));
      chk($sformatf("row%0d fill", i), 64'(fill_req_mm5), 64'(tbl[i].fill));
      chk($sformatf("row%0d idle", i), 64'(idle), 64'(tbl[i].idl));
      if (tbl[i].v5) begin
        chk($sformatf("row%0d addr5", i), 64'(pipe_req_pkt_mm5.addr), 64'(tbl[i].a5));
        chk($sformatf("row%0d id5", i), 64'(pipe_req_pkt_mm5.id), 64'(tbl[i].id5));
      end
      @(posedge clk); #1;
    end
    eg = '{3'b010, 3'b100, 3'b001};
    for (int c = 0; c < 3; c++) begin
      drive(0, 3'b111, 0, 1, 32'h3000);
      #1;
      chk($sformatf("flight gnt%0d", c), 64'(gnt_mm0), 64'(eg[c]));
      @(posedge clk); #1;
    end
    drive(1, 3'b111, 0, 1, 32'h3000);
    #1;
    chk("rst gnt", 64'(gnt_mm0), 64'(3'b000));
    @(posedge clk); #1;
    drive(0, 3'b000, 0, 1, 32'h3000);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("post-rst valid5 c%0d", c), 64'(pipe_valid_mm5), 64'(0));
      chk($sformatf("post-rst idle c%0d", c), 64'(idle), 64'(1));
      @(posedge clk); #1;
    end
    drive(0, 3'b111, 0, 1, 32'h3000);
    #1;
    chk("post-rst gnt", 64'(gnt_mm0), 64'(3'b001));
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
